// File: rtl/tty_pkg.sv
// tty_pkg: register map, status/ctrl bit positions and TX drain FSM states for tty_ctrl.
package tty_pkg;
  localparam logic [1:0] A_RXDATA = 2'd0;
  localparam logic [1:0] A_TXDATA = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;
  localparam int ST_RX_VALID = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_FULL  = 2;
  localparam int ST_TX_EMPTY = 3;
  localparam int ST_OVERRUN  = 4;
  localparam int CT_IRQ_EN  = 0;
  localparam int CT_CLR_OVR = 1;
  localparam logic [7:0] EMPTY_CODE_DEF = 8'hFF;
  typedef enum logic [1:0] {IDLE, WRITE, GAP} tx_state_e;
endpackage

// File: rtl/tty_if.sv
// tty_if: CPU register bus between a bus master and tty_ctrl.
interface tty_if #(parameter int DATA_W = 32);
  logic [1:0]        bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_wr;
  logic              bus_rd;
  logic [DATA_W-1:0] bus_rdata;
  modport master (output bus_addr, bus_wdata, bus_wr, bus_rd, input bus_rdata);
  modport slave  (input bus_addr, bus_wdata, bus_wr, bus_rd, output bus_rdata);
endinterface

// File: rtl/tty_fifo.sv
// tty_fifo: synchronous FIFO; a push on a full FIFO lands only when a pop frees a slot in the same cycle.
module tty_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  logic do_pop, do_push;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_q + AW'(do_pop);
      wr_q <= wr_q + AW'(do_push);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= wdata_i;
endmodule

// File: rtl/tty_ctrl.sv
// tty_ctrl: keyboard RX FIFO, CPU TX FIFO drained to the video engine, 4-register bus map.
// Optional: define TTY_LOCAL_ECHO_EN to echo every RX byte into the TX FIFO.
module tty_ctrl import tty_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16,
  parameter logic [7:0] EMPTY_CODE = EMPTY_CODE_DEF
) (
  input  logic       clk_50mhz,
  input  logic       rst_n,
  tty_if.slave       bus,
  input  logic [7:0] kb_ascii,
  input  logic       kb_released,
  output logic [7:0] vm_data,
  output logic       vm_write,
  input  logic       vm_busy,
  output logic       irq
);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);
  logic kb_q, irq_q, irq_d, irq_en_q, irq_en_d, ovr_q, ovr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0] vm_data_q, vm_data_d, status, rx_head, tx_head, tx_wdata;
  tx_state_e state_q, state_d;
  logic kb_rise, rd_rx, wr_tx, wr_ctrl, ovr_set;
  logic rx_full, rx_empty, tx_full, tx_empty, tx_push, tx_pop;
  logic [RAW:0] rx_cnt;
  logic [TAW:0] tx_cnt;
  assign kb_rise = kb_released & ~kb_q;
  assign rd_rx = bus.bus_rd & (bus.bus_addr == A_RXDATA);
  assign wr_tx = bus.bus_wr & (bus.bus_addr == A_TXDATA);
  assign wr_ctrl = bus.bus_wr & (bus.bus_addr == A_CTRL);
  assign ovr_set = kb_rise & rx_full & ~rd_rx;
  tty_fifo #(.W(8), .DEPTH(RX_DEPTH)) u_rx (
    .clk(clk_50mhz), .rst_n(rst_n), .push_i(kb_rise), .pop_i(rd_rx), .wdata_i(kb_ascii),
    .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt)
  );
  tty_fifo #(.W(8), .DEPTH(TX_DEPTH)) u_tx (
    .clk(clk_50mhz), .rst_n(rst_n), .push_i(tx_push), .pop_i(tx_pop), .wdata_i(tx_wdata),
    .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt)
  );
`ifdef TTY_LOCAL_ECHO_EN
  logic rx_pushed, pend_q, pend_d;
  logic [7:0] pend_byte_q, pend_byte_d;
  assign rx_pushed = kb_rise & (~rx_full | rd_rx);
  // CPU write wins the TX port; an echo byte colliding with it is parked for one cycle.
  always_comb begin
    tx_push = wr_tx | pend_q | rx_pushed;
    tx_wdata = wr_tx ? bus.bus_wdata[7:0] : pend_q ? pend_byte_q : kb_ascii;
    pend_d = wr_tx & (pend_q | rx_pushed);
    pend_byte_d = (wr_tx & ~pend_q & rx_pushed) ? kb_ascii : pend_byte_q;
  end
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      pend_byte_q <= '0;
    end else begin
      pend_q <= pend_d;
      pend_byte_q <= pend_byte_d;
    end
  end
`else
  assign tx_push = wr_tx;
  assign tx_wdata = bus.bus_wdata[7:0];
`endif
  always_comb begin
    status = '0;
    status[ST_RX_VALID] = |rx_cnt;
    status[ST_RX_FULL] = rx_full;
    status[ST_TX_FULL] = tx_full;
    status[ST_TX_EMPTY] = tx_cnt == '0;
    status[ST_OVERRUN] = ovr_q;
    rdata_d = ~bus.bus_rd ? rdata_q
            : bus.bus_addr == A_RXDATA ? DATA_W'(rx_empty ? EMPTY_CODE : rx_head)
            : bus.bus_addr == A_STATUS ? DATA_W'(status)
            : bus.bus_addr == A_CTRL ? DATA_W'(irq_en_q) : '0;
    irq_en_d = wr_ctrl ? bus.bus_wdata[CT_IRQ_EN] : irq_en_q;
    ovr_d = (ovr_q & ~(wr_ctrl & bus.bus_wdata[CT_CLR_OVR])) | ovr_set;
    irq_d = irq_en_q & (~rx_empty | ovr_q);
  end
  // The head is popped on entry to WRITE so vm_data is already registered during the pulse.
  always_comb begin
    tx_pop = (state_q == IDLE) & ~tx_empty & ~vm_busy;
    state_d = tx_pop ? WRITE : (state_q == WRITE) ? GAP : IDLE;
    vm_data_d = tx_pop ? tx_head : vm_data_q;
  end
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      kb_q <= 1'b0;
      irq_q <= 1'b0;
      irq_en_q <= 1'b0;
      ovr_q <= 1'b0;
      rdata_q <= '0;
      vm_data_q <= '0;
      state_q <= IDLE;
    end else begin
      kb_q <= kb_released;
      irq_q <= irq_d;
      irq_en_q <= irq_en_d;
      ovr_q <= ovr_d;
      rdata_q <= rdata_d;
      vm_data_q <= vm_data_d;
      state_q <= state_d;
    end
  end
  assign bus.bus_rdata = rdata_q;
  assign vm_data = vm_data_q;
  assign vm_write = rst_n & (state_q == WRITE);
  assign irq = irq_q;
endmodule
